// File: rtl/cfg_rd_arbiter.sv
// Round-robin arbiter sharing the core's cfg read port among NUM_REQ requesters, one read in flight.
// Define CFG_RD_ARB_TIMEOUT_EN to enable per-attempt timeout with up to MAX_RETRY re-issues.
module cfg_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT_W = 9,
    parameter int MAX_RETRY = 3
) (
    input  logic                  trn_clk,
    input  logic                  trn_reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*10-1:0] req_dwaddr,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [9:0]            cfg_dwaddr,
    output logic                  cfg_rd_en_n,
    input  logic [31:0]           cfg_do,
    input  logic                  cfg_rd_wr_done_n
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;
    logic [9:0]           cfg_dwaddr_q, cfg_dwaddr_d;
    logic                 cfg_rd_en_n_q, cfg_rd_en_n_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic                 busy_q, busy_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [9:0]           pick_addr;
    int                   cand;

`ifdef CFG_RD_ARB_TIMEOUT_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
    logic [RTY_W-1:0]     retry_q, retry_d;
    logic                 rsp_err_q, rsp_err_d;
`endif

    // Search starts one past the last grant and wraps, so every requester is served in turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_gnt_q) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!pick_found && req_valid[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) pick_addr = req_dwaddr[i*10 +: 10];
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_gnt_d    = last_gnt_q;
        cfg_dwaddr_d  = cfg_dwaddr_q;
        cfg_rd_en_n_d = 1'b1;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
`ifdef CFG_RD_ARB_TIMEOUT_EN
        timeout_d     = timeout_q;
        retry_d       = retry_q;
        rsp_err_d     = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d         = pick_idx;
                    last_gnt_d    = pick_idx;
                    cfg_dwaddr_d  = pick_addr;
                    cfg_rd_en_n_d = 1'b0;
                    state_d       = ST_WAIT;
`ifdef CFG_RD_ARB_TIMEOUT_EN
                    timeout_d     = '0;
                    retry_d       = '0;
`endif
                end
            end
            ST_WAIT: begin
                // Done takes precedence over an expiring timeout in the same cycle.
                if (!cfg_rd_wr_done_n) begin
                    rsp_data_d  = cfg_do;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    state_d     = ST_RESP;
`ifdef CFG_RD_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (timeout_q == '1) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d       = retry_q + 1'b1;
                        timeout_d     = '0;
                        cfg_rd_en_n_d = 1'b0;
                    end else begin
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = NUM_REQ'(1) << gnt_q;
                        state_d     = ST_RESP;
                    end
                end else begin
                    timeout_d = timeout_q + 1'b1;
`endif
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            last_gnt_q    <= IDX_W'(NUM_REQ - 1);
            cfg_dwaddr_q  <= '0;
            cfg_rd_en_n_q <= 1'b1;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
`ifdef CFG_RD_ARB_TIMEOUT_EN
            timeout_q     <= '0;
            retry_q       <= '0;
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_gnt_q    <= last_gnt_d;
            cfg_dwaddr_q  <= cfg_dwaddr_d;
            cfg_rd_en_n_q <= cfg_rd_en_n_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            busy_q        <= busy_d;
`ifdef CFG_RD_ARB_TIMEOUT_EN
            timeout_q     <= timeout_d;
            retry_q       <= retry_d;
            rsp_err_q     <= rsp_err_d;
`endif
        end
    end

    assign cfg_dwaddr  = cfg_dwaddr_q;
    assign cfg_rd_en_n = cfg_rd_en_n_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
`ifdef CFG_RD_ARB_TIMEOUT_EN
    assign rsp_err     = rsp_err_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_rd_arbiter.sv
// Scoreboard bench for cfg_rd_arbiter: stimulus pushes expected strobes/responses, a monitor pops and compares.
module tb_cfg_rd_arbiter;
    localparam int N = 4;

    logic            trn_clk = 1'b0;
    logic            trn_reset_n;
    logic [N-1:0]    req_valid;
    logic [N*10-1:0] req_dwaddr = '0;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic            busy;
    logic [9:0]      cfg_dwaddr;
    logic            cfg_rd_en_n;
    logic [31:0]     cfg_do = '0;
    logic            cfg_rd_wr_done_n = 1'b1;

    always #5 trn_clk = ~trn_clk;

    cfg_rd_arbiter #(.NUM_REQ(N), .TIMEOUT_W(9), .MAX_RETRY(3)) dut (
        .trn_clk(trn_clk), .trn_reset_n(trn_reset_n),
        .req_valid(req_valid), .req_dwaddr(req_dwaddr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .cfg_dwaddr(cfg_dwaddr), .cfg_rd_en_n(cfg_rd_en_n),
        .cfg_do(cfg_do), .cfg_rd_wr_done_n(cfg_rd_wr_done_n)
    );

    typedef struct {
        logic [N-1:0] vld;
        logic [31:0]  data;
        logic         err;
    } rsp_t;

    rsp_t       exp_rsp[$];
    logic [9:0] exp_addr[$];
    int         strobe_log[$];
    int         raise_cnt [N] = '{default: 0};
    int         served_cnt[N] = '{default: 0};
    int         n_vec = 0, n_err = 0;
    int         cyc = 0;
    bit         prev_rsp = 1'b0;

    // Core model knobs: answer `core_delay` negedges after the `core_on_attempt`-th strobe (-1: never).
    int          core_delay = -1, core_on_attempt = 1;
    bit          core_fixed = 1'b0;
    logic [31:0] core_data = '0;
    int          core_cnt = -1, attempt = 0;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < N; i++) req_valid[i] = (raise_cnt[i] != served_cnt[i]);
    end

    always @(posedge trn_clk) cyc <= cyc + 1;

    function automatic logic [31:0] data_of(input logic [9:0] a);
        return {16'hC0DE, 6'h0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge trn_clk) begin
        cfg_rd_wr_done_n = 1'b1;
        if (!busy) attempt = 0;
        if (!cfg_rd_en_n) begin
            attempt++;
            if (core_delay >= 0 && attempt == core_on_attempt) core_cnt = core_delay;
        end
        if (core_cnt == 0) begin
            cfg_rd_wr_done_n = 1'b0;
            cfg_do = core_fixed ? core_data : data_of(cfg_dwaddr);
            core_cnt = -1;
        end else if (core_cnt > 0) begin
            core_cnt--;
        end
    end

    // Monitor: every strobe and every response must match the head of its queue.
    always @(negedge trn_clk) begin
        rsp_t e;
        if (trn_reset_n) begin
            if (!cfg_rd_en_n) begin
                strobe_log.push_back(cyc);
                chk("strobe_expected", 32'(exp_addr.size() > 0), 1);
                if (exp_addr.size() > 0) chk("strobe_addr", 32'(cfg_dwaddr), 32'(exp_addr.pop_front()));
            end
            if (prev_rsp) begin
                chk("rsp_one_cycle", 32'(rsp_valid), 0);
                chk("busy_after_rsp", 32'(busy), 0);
            end
            if (rsp_valid != '0) begin
                chk("rsp_expected", 32'(exp_rsp.size() > 0), 1);
                if (exp_rsp.size() > 0) begin
                    e = exp_rsp.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("busy_in_rsp", 32'(busy), 1);
                end
                for (int i = 0; i < N; i++) if (rsp_valid[i]) served_cnt[i]++;
            end
            prev_rsp = (rsp_valid != '0);
        end
    end

    task automatic raise(input int i, input logic [9:0] a);
        req_dwaddr[i*10 +: 10] = a;
        raise_cnt[i]++;
    endtask

    task automatic expect_rd(input int i, input logic [9:0] a, input logic [31:0] d, input logic e,
                             input int strobes);
        rsp_t r;
        for (int k = 0; k < strobes; k++) exp_addr.push_back(a);
        r.vld  = N'(1) << i;
        r.data = d;
        r.err  = e;
        exp_rsp.push_back(r);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while ((exp_rsp.size() != 0 || busy || req_valid != '0) && t < budget) begin
            @(negedge trn_clk);
            t++;
        end
        chk("drain_in_budget", 32'(t < budget), 1);
        repeat (2) @(negedge trn_clk);
        chk("strobes_consumed", 32'(exp_addr.size()), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cfg_rd_en_n"}, 32'(cfg_rd_en_n), 1);
        chk({tag, "_cfg_dwaddr"}, 32'(cfg_dwaddr), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t;
        trn_reset_n = 1'b0;
        repeat (2) @(negedge trn_clk);
        chk_reset_outputs("reset");
        trn_reset_n = 1'b1;
        repeat (2) @(negedge trn_clk);

        // T2a: all four at once from reset -> 0,1,2,3
        core_delay = 0; core_on_attempt = 1; core_fixed = 1'b0;
        expect_rd(0, 10'h023, data_of(10'h023), 1'b0, 1);
        expect_rd(1, 10'h024, data_of(10'h024), 1'b0, 1);
        expect_rd(2, 10'h025, data_of(10'h025), 1'b0, 1);
        expect_rd(3, 10'h001, data_of(10'h001), 1'b0, 1);
        raise(0, 10'h023); raise(1, 10'h024); raise(2, 10'h025); raise(3, 10'h001);
        drain(200);

        // T2b: req 1 alone, then 0 and 2 raised while 1 is waiting -> 1,2,0
        core_delay = 6;
        expect_rd(1, 10'h024, data_of(10'h024), 1'b0, 1);
        expect_rd(2, 10'h025, data_of(10'h025), 1'b0, 1);
        expect_rd(0, 10'h023, data_of(10'h023), 1'b0, 1);
        raise(1, 10'h024);
        repeat (2) @(negedge trn_clk);
        raise(0, 10'h023); raise(2, 10'h025);
        drain(200);

        // T1: single read, done 3 cycles after strobe
        core_delay = 3; core_fixed = 1'b1; core_data = 32'hFEEF_F00C;
        base = strobe_log.size();
        expect_rd(0, 10'h023, 32'hFEEF_F00C, 1'b0, 1);
        raise(0, 10'h023);
        drain(200);
        chk("t1_strobe_count", 32'(strobe_log.size() - base), 1);

        // T5: reset while waiting; late done ignored; arbitration restarts at req 0
        core_delay = 10; core_fixed = 1'b0;
        exp_addr.push_back(10'h040);
        raise(0, 10'h040);
        t = 0;
        while (exp_addr.size() != 0 && t < 20) begin
            @(negedge trn_clk);
            t++;
        end
        chk("t5_strobe_seen", 32'(t < 20), 1);
        @(negedge trn_clk);
        #2 trn_reset_n = 1'b0;
        #1 chk_reset_outputs("t5_async");
        raise_cnt[0] = served_cnt[0];
        @(negedge trn_clk);
        trn_reset_n = 1'b1;
        repeat (15) @(negedge trn_clk);
        chk("t5_idle_after_late_done", 32'(busy), 0);
        core_delay = 0;
        expect_rd(0, 10'h041, data_of(10'h041), 1'b0, 1);
        expect_rd(1, 10'h042, data_of(10'h042), 1'b0, 1);
        raise(0, 10'h041); raise(1, 10'h042);
        drain(200);

`ifdef CFG_RD_ARB_TIMEOUT_EN
        // T3: no done ever -> 4 strobes 512 apart, then error response
        core_delay = -1;
        base = strobe_log.size();
        expect_rd(3, 10'h155, 32'h0, 1'b1, 4);
        raise(3, 10'h155);
        drain(3000);
        chk("t3_strobe_count", 32'(strobe_log.size() - base), 4);
        if (strobe_log.size() >= base + 4) begin
            for (int k = 1; k < 4; k++)
                chk("t3_strobe_spacing", 32'(strobe_log[base+k] - strobe_log[base+k-1]), 512);
        end

        // T4: done on third attempt -> good data, no fourth strobe
        core_delay = 0; core_on_attempt = 3; core_fixed = 1'b1; core_data = 32'h0000_4162;
        base = strobe_log.size();
        expect_rd(1, 10'h0AA, 32'h0000_4162, 1'b0, 3);
        raise(1, 10'h0AA);
        drain(3000);
        chk("t4_strobe_count", 32'(strobe_log.size() - base), 3);
`else
        // T6: very slow core without timeout -> one strobe, normal response
        core_delay = 2000; core_on_attempt = 1; core_fixed = 1'b1; core_data = 32'h1234_5678;
        base = strobe_log.size();
        expect_rd(2, 10'h3FF, 32'h1234_5678, 1'b0, 1);
        raise(2, 10'h3FF);
        drain(3000);
        chk("t6_strobe_count", 32'(strobe_log.size() - base), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
